sipo_deser: RTL and testbench

Parametrised serial-to-parallel deserializer, the successor to the team's plain SIPO shift register. Adds a bit strobe, selectable bit order, a one-word output holding register with valid/ready handshake, sticky overflow detection and an optional parity check. Sits between a serial line front-end (UART/SPI-style bit sampler) and word-oriented logic.

---
 rtl/sipo_deser_pkg.sv | 21 ++
 rtl/sipo_deser_hold.sv | 80 ++++++++
 rtl/sipo_deser.sv | 145 ++++++++++++++
 tb/tb_sipo_deser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserializer.
// Optional parity support is enabled by defining SIPO_DESER_PARITY_EN.
package sipo_deser_pkg;

    // Frame collection states; PAR is only reachable in parity builds.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    // Parity sense selectors for the PARITY_ODD parameter.
    localparam int PARITY_SENSE_EVEN = 0;
    localparam int PARITY_SENSE_ODD  = 1;

    // Counter width able to hold 0..n (n is reached only while awaiting parity).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_deser_hold.sv
// One-word output holding register with valid/ready handshake and sticky
// overflow. A word completing while the held word is unconsumed is dropped.
// With SIPO_DESER_PARITY_EN the parity flag travels with the held word.
module sipo_deser_hold
    import sipo_deser_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [N-1:0] word_i,
`ifdef SIPO_DESER_PARITY_EN
    input  logic         perr_i,
    output logic         perr_o,
`endif
    input  logic         ready_i,
    output logic [N-1:0] data_o,
    output logic         valid_o,
    output logic         overflow_o
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         perr_q, perr_d;

    // Next-state: flush, load/drop on completion, or retire on accept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        perr_d  = perr_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            perr_d  = 1'b0;
        end else if (load_i) begin
            if (valid_q && !ready_i) begin
                ovf_d = 1'b1;
            end else begin
                data_d  = word_i;
                valid_d = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
                perr_d  = perr_i;
`endif
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
`ifdef SIPO_DESER_PARITY_EN
    assign perr_o     = perr_q;
`else
    // Without parity the flag register is constant zero and never observed.
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserializer: bit strobe, selectable bit
// order, one-word holding register with valid/ready, sticky overflow.
// Define SIPO_DESER_PARITY_EN for an extra parity bit per frame and the
// parity_err_o output.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int N          = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         serial_i,
    input  logic         serial_valid_i,
    output logic [N-1:0] parallel_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         overflow_o,
    output logic         busy_o
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic         parity_err_o
`endif
);

    localparam int CW = cnt_width(N);

    // Elaboration-time parameter legality.
    if (N < 2) begin : g_bad_n
        $error("sipo_deser: N must be at least 2");
    end
    if (PARITY_ODD != PARITY_SENSE_EVEN && PARITY_ODD != PARITY_SENSE_ODD) begin : g_bad_parity
        $error("sipo_deser: PARITY_ODD must be 0 or 1");
    end

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] sr_q, sr_d;
    logic         busy_q, busy_d;
    logic [N-1:0] shifted;
    logic [N-1:0] word_c;
    logic         complete_c;
    logic         perr_c;

    // Shift register value after sampling serial_i in the configured order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {sr_q[N-2:0], serial_i};
        end else begin
            shifted = {serial_i, sr_q[N-1:1]};
        end
    end

    // FSM next-state, counter and shift datapath; flags frame completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        word_c     = shifted;
        complete_c = 1'b0;
        perr_c     = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (serial_valid_i) begin
            case (state_q)
                IDLE, SHIFT: begin
                    sr_d = shifted;
                    if (cnt_q == CW'(N - 1)) begin
`ifdef SIPO_DESER_PARITY_EN
                        state_d = PAR;
                        cnt_d   = CW'(N);
`else
                        state_d    = IDLE;
                        cnt_d      = '0;
                        complete_c = 1'b1;
`endif
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                PAR: begin
                    // Parity bit is checked, not shifted into the word.
                    word_c     = sr_q;
                    perr_c     = ((^sr_q) ^ serial_i) != 1'(PARITY_ODD);
                    complete_c = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    // FSM, counter, shift register and busy flag state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

    sipo_deser_hold #(
        .N (N)
    ) u_hold (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .load_i     (complete_c),
        .word_i     (word_c),
`ifdef SIPO_DESER_PARITY_EN
        .perr_i     (perr_c),
        .perr_o     (parity_err_o),
`endif
        .ready_i    (ready_i),
        .data_o     (parallel_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

`ifndef SIPO_DESER_PARITY_EN
    logic unused_perr_c;
    assign unused_perr_c = perr_c;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: an MSB-first and an LSB-first instance
// share stimulus and are compared against a frame-level reference model.
module tb_sipo_deser;

    localparam int N    = 8;
    localparam int PODD = 0;
`ifdef SIPO_DESER_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    logic clear_i = 1'b0;
    logic serial_i = 1'b0;
    logic serial_valid_i = 1'b0;
    logic ready_i = 1'b0;

    logic [N-1:0] m_par, l_par;
    logic m_valid, l_valid, m_ovf, l_ovf, m_busy, l_busy, m_perr, l_perr;

    always #5 clk = ~clk;

    sipo_deser #(.N(N), .MSB_FIRST(1), .PARITY_ODD(PODD)) u_msb (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .serial_i(serial_i),
        .serial_valid_i(serial_valid_i), .parallel_o(m_par), .valid_o(m_valid),
        .ready_i(ready_i), .overflow_o(m_ovf), .busy_o(m_busy)
`ifdef SIPO_DESER_PARITY_EN
        , .parity_err_o(m_perr)
`endif
    );

    sipo_deser #(.N(N), .MSB_FIRST(0), .PARITY_ODD(PODD)) u_lsb (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .serial_i(serial_i),
        .serial_valid_i(serial_valid_i), .parallel_o(l_par), .valid_o(l_valid),
        .ready_i(ready_i), .overflow_o(l_ovf), .busy_o(l_busy)
`ifdef SIPO_DESER_PARITY_EN
        , .parity_err_o(l_perr)
`endif
    );

`ifndef SIPO_DESER_PARITY_EN
    assign m_perr = 1'b0;
    assign l_perr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: received bits of the current frame, plus held outputs.
    bit           bits_q[$];
    logic [N-1:0] e_msb, e_lsb;
    logic         e_valid, e_ovf, e_perr;

    wire [2*N+9:0] obs = {m_par, l_par, m_valid, l_valid, m_ovf, l_ovf,
                          m_busy, l_busy, m_perr, l_perr};

    function automatic logic [2*N+9:0] exp_vec();
        logic b;
        b = (bits_q.size() != 0);
        return {e_msb, e_lsb, e_valid, e_valid, e_ovf, e_ovf, b, b, e_perr, e_perr};
    endfunction

    task automatic model_reset();
        bits_q.delete();
        e_msb = '0; e_lsb = '0; e_valid = 1'b0; e_ovf = 1'b0; e_perr = 1'b0;
    endtask

    // One clock edge of the model with the given inputs.
    task automatic model_edge(input logic ser, input logic sv, input logic rdy, input logic clr);
        bit           done;
        logic [N-1:0] wm, wl;
        logic         pe;
        done = 0; wm = '0; wl = '0; pe = 1'b0;
        if (clr) begin
            bits_q.delete();
            e_valid = 1'b0; e_ovf = 1'b0; e_perr = 1'b0;
        end else begin
            if (sv) begin
                bits_q.push_back(ser);
                if (bits_q.size() == FRAME) begin
                    done = 1;
                    for (int i = 0; i < N; i++) begin
                        wm[N-1-i] = bits_q[i];
                        wl[i]     = bits_q[i];
                        pe        = pe ^ bits_q[i];
                    end
                    if (FRAME > N) pe = ((pe ^ bits_q[N]) != (PODD == 1));
                    else           pe = 1'b0;
                    bits_q.delete();
                end
            end
            if (done) begin
                if (e_valid && !rdy) begin
                    e_ovf = 1'b1;
                end else begin
                    e_msb = wm; e_lsb = wl; e_perr = pe; e_valid = 1'b1;
                end
            end else if (e_valid && rdy) begin
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic ser, input logic sv, input logic rdy, input logic clr);
        @(negedge clk);
        serial_i = ser; serial_valid_i = sv; ready_i = rdy; clear_i = clr;
        model_edge(ser, sv, rdy, clr);
        @(posedge clk);
        #1;
        serial_valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
    endtask

    // Sends w first-bit-first as bits w[N-1]..w[0], plus a correct parity bit
    // in parity builds; rdy_last drives ready_i on the completing strobe.
    task automatic send_word(input logic [N-1:0] w, input logic rdy_last);
        logic p;
        for (int i = 0; i < N; i++)
            step(w[N-1-i], 1'b1, (i == N-1 && FRAME == N) ? rdy_last : 1'b0, 1'b0);
        if (FRAME > N) begin
            p = (^w) ^ (PODD == 1);
            step(p, 1'b1, rdy_last, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs obs=%h exp=0", obs);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_bit_order();
        logic [N-1:0] w;
        w = 8'hA5;
        for (int i = 0; i < N; i++) begin
            step(w[N-1-i], 1'b1, 1'b0, 1'b0);
            if (i == N-2) begin
                checks++;
                if (m_valid !== 1'b0 || m_busy !== 1'b1) begin
                    errors++; $display("FAIL a5_before_last valid=%b busy=%b exp valid=0 busy=1", m_valid, m_busy);
                end
            end
        end
        if (FRAME > N) step((^w) ^ (PODD == 1), 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_par !== 8'hA5 || l_par !== 8'hA5 || m_valid !== 1'b1 || m_busy !== 1'b0) begin
            errors++; $display("FAIL a5_word msb=%h lsb=%h valid=%b busy=%b exp A5 A5 1 0", m_par, l_par, m_valid, m_busy);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL a5_model obs=%h exp=%h", obs, exp_vec());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL a5_accept valid=%b exp=0", m_valid);
        end
        send_word(8'hC0, 1'b0);
        checks++;
        if (m_par !== 8'hC0 || l_par !== 8'h03 || m_ovf !== 1'b0) begin
            errors++; $display("FAIL c0_order msb=%h lsb=%h ovf=%b exp C0 03 0", m_par, l_par, m_ovf);
        end
        $display("test_bit_order done");
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0);
        send_word(8'hFF, 1'b0);
        checks++;
        if (m_par !== 8'h3C || m_ovf !== 1'b1 || m_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_drop par=%h ovf=%b valid=%b exp 3C 1 1", m_par, m_ovf, m_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (m_ovf !== 1'b1 || m_valid !== 1'b0 || m_par !== 8'h3C) begin
            errors++; $display("FAIL ovf_sticky ovf=%b valid=%b par=%h exp 1 0 3C", m_ovf, m_valid, m_par);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (m_ovf !== 1'b0 || l_ovf !== 1'b0 || m_par !== 8'h3C) begin
            errors++; $display("FAIL ovf_clear ovf=%b par=%h exp 0 3C", m_ovf, m_par);
        end
        $display("test_overflow done");
    endtask

    task automatic test_simultaneous();
        send_word(8'h55, 1'b0);
        send_word(8'h81, 1'b1);
        checks++;
        if (m_par !== 8'h81 || l_par !== 8'h81 || m_valid !== 1'b1 || m_ovf !== 1'b0) begin
            errors++; $display("FAIL simul_accept par=%h valid=%b ovf=%b exp 81 1 0", m_par, m_valid, m_ovf);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL simul_model obs=%h exp=%h", obs, exp_vec());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        $display("test_simultaneous done");
    endtask

    task automatic test_mid_frame_clear();
        for (int i = 0; i < 5; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL clear_mid busy=%b valid=%b exp 0 0", m_busy, m_valid);
        end
        send_word(8'h5A, 1'b0);
        checks++;
        if (m_par !== 8'h5A || l_par !== 8'h5A || m_valid !== 1'b1) begin
            errors++; $display("FAIL clear_5a msb=%h lsb=%h valid=%b exp 5A 5A 1", m_par, l_par, m_valid);
        end
        $display("test_mid_frame_clear done");
    endtask

    task automatic test_mid_frame_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_mid obs=%h exp=0", obs);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        send_word(8'h5A, 1'b0);
        checks++;
        if (m_par !== 8'h5A || l_par !== 8'h5A || m_busy !== 1'b0) begin
            errors++; $display("FAIL reset_5a msb=%h lsb=%h busy=%b exp 5A 5A 0", m_par, l_par, m_busy);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_vec());
        end
        $display("test_mid_frame_reset done");
    endtask

`ifdef SIPO_DESER_PARITY_EN
    task automatic test_parity();
        logic [N-1:0] w;
        w = 8'h07;
        for (int pb = 1; pb >= 0; pb--) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < N; i++) step(w[N-1-i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (m_valid !== 1'b0 || m_busy !== 1'b1) begin
                errors++; $display("FAIL par_wait%0d valid=%b busy=%b exp 0 1", pb, m_valid, m_busy);
            end
            step(1'(pb), 1'b1, 1'b0, 1'b0);
            checks++;
            if (m_valid !== 1'b1 || m_par !== 8'h07 || m_perr !== 1'(pb == 0) || l_perr !== 1'(pb == 0)) begin
                errors++; $display("FAIL par_bit%0d valid=%b par=%h perr=%b exp 1 07 %b", pb, m_valid, m_par, m_perr, 1'(pb == 0));
            end
        end
        $display("test_parity done");
    endtask
`endif

    task automatic test_random_back_to_back();
        logic ser, sv, rdy, clr;
        int bad;
        bad = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            ser = 1'($urandom_range(1));
            sv  = ($urandom_range(99) < ((i < 300) ? 95 : 60));
            rdy = ($urandom_range(99) < 35);
            clr = ($urandom_range(99) < 2);
            step(ser, sv, rdy, clr);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; bad++;
                if (bad <= 10) $display("FAIL random_cycle%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        $display("test_random_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_overflow();
        test_simultaneous();
        test_mid_frame_clear();
        test_mid_frame_reset();
`ifdef SIPO_DESER_PARITY_EN
        test_parity();
`endif
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
